// File: rtl/funct_generator_pkg.sv
// Shared types and default sizing for the function-generator datapath.
package funct_generator_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_DIV_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10,
    XX    = 'x
  } gen_state_e;

endpackage

// File: rtl/funct_generator_wave_ram.sv
// Waveform table: DEPTH x DATA_W registers, synchronous write, combinational read.
module funct_generator_wave_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/funct_generator_wave_engine.sv
// Loads a sample table in config mode and replays it cyclically every div_i+1 cycles
// as a valid/ready stream (first sample 1 cycle after RUN); FG_STALL_CNT_EN adds stall_cnt_o.
module funct_generator_wave_engine
  import funct_generator_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DIV_W  = DEF_DIV_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int LEN_W = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clrh_addr_i,
  input  logic              enh_config_i,
  input  logic              enh_gen_i,
  input  logic [DATA_W-1:0] cfg_data_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [DIV_W-1:0]  div_i,
  output logic [DATA_W-1:0] sample_o,
  output logic              sample_valid_o,
  input  logic              sample_ready_i,
`ifdef FG_STALL_CNT_EN
  output logic [15:0]       stall_cnt_o,
`endif
  output logic [LEN_W-1:0]  len_o
);

  logic              cfg_prev;
  logic              session_start;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr;
  logic [AW-1:0]     rd_wrap;
  logic [DATA_W-1:0] rd_data;
  logic [DIV_W-1:0]  div_cnt;
  logic              gen_ok;
  logic              pending;

  gen_state_e        state, state_nxt;
  logic [AW-1:0]     rd_nxt;
  logic [DIV_W-1:0]  div_nxt;
  logic [DATA_W-1:0] smp_nxt;
  logic              vld_nxt;

  // Config write path runs independently of the generator, so a clear never disturbs a load.
  assign session_start = enh_config_i && !cfg_prev;
  assign cfg_ready_o   = enh_config_i && !session_start && (len_o < LEN_W'(DEPTH));
  assign wr_en         = cfg_valid_i && cfg_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_prev <= 1'b0;
      wr_addr  <= '0;
      len_o    <= '0;
    end else begin
      cfg_prev <= enh_config_i;
      if (session_start) begin
        wr_addr <= '0;
        len_o   <= '0;
      end else if (wr_en) begin
        wr_addr <= wr_addr + AW'(1);
        len_o   <= len_o + LEN_W'(1);
      end
    end
  end

  funct_generator_wave_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (cfg_data_i),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign gen_ok  = enh_gen_i && !enh_config_i;
  assign pending = sample_valid_o && !sample_ready_i;
  // >= keeps the pointer in range even if a shorter table was loaded since the last clear.
  assign rd_wrap = ({1'b0, rd_addr} >= (len_o - LEN_W'(1))) ? '0 : rd_addr + AW'(1);

  always_comb begin
    state_nxt = state;
    rd_nxt    = rd_addr;
    div_nxt   = div_cnt;
    smp_nxt   = sample_o;
    vld_nxt   = sample_valid_o;
    if (clrh_addr_i) begin
      rd_nxt    = '0;
      div_nxt   = div_i;
      vld_nxt   = 1'b0;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (gen_ok && (len_o != '0)) begin
            state_nxt = RUN;
            div_nxt   = '0;
          end
        end
        RUN: begin
          if (pending) begin
            state_nxt = STALL;
          end else if (!gen_ok) begin
            vld_nxt   = 1'b0;
            state_nxt = IDLE;
          end else if (div_cnt == '0) begin
            smp_nxt = rd_data;
            vld_nxt = 1'b1;
            div_nxt = div_i;
            rd_nxt  = rd_wrap;
          end else begin
            vld_nxt = 1'b0;
            div_nxt = div_cnt - DIV_W'(1);
          end
        end
        STALL: begin
          if (sample_ready_i) begin
            vld_nxt   = 1'b0;
            state_nxt = RUN;
          end
        end
        default: state_nxt = XX;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rd_addr        <= '0;
      div_cnt        <= '0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
    end else begin
      state          <= state_nxt;
      rd_addr        <= rd_nxt;
      div_cnt        <= div_nxt;
      sample_o       <= smp_nxt;
      sample_valid_o <= vld_nxt;
    end
  end

`ifdef FG_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (clrh_addr_i) begin
      stall_cnt_o <= '0;
    end else if (pending && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_funct_generator_wave_engine.sv
// Randomised and directed bench for funct_generator_wave_engine against a behavioural model.
module tb_funct_generator_wave_engine;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int DIV_W  = 8;
  localparam int LEN_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clrh_addr_i = 1'b0;
  logic              enh_config_i = 1'b0;
  logic              enh_gen_i = 1'b0;
  logic [DATA_W-1:0] cfg_data_i = '0;
  logic              cfg_valid_i = 1'b0;
  logic              cfg_ready_o;
  logic [DIV_W-1:0]  div_i = '0;
  logic [DATA_W-1:0] sample_o;
  logic              sample_valid_o;
  logic              sample_ready_i = 1'b0;
  logic [LEN_W-1:0]  len_o;
`ifdef FG_STALL_CNT_EN
  logic [15:0]       stall_cnt_o;
`endif

  funct_generator_wave_engine #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .DIV_W  (DIV_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clrh_addr_i    (clrh_addr_i),
    .enh_config_i   (enh_config_i),
    .enh_gen_i      (enh_gen_i),
    .cfg_data_i     (cfg_data_i),
    .cfg_valid_i    (cfg_valid_i),
    .cfg_ready_o    (cfg_ready_o),
    .div_i          (div_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .sample_ready_i (sample_ready_i),
`ifdef FG_STALL_CNT_EN
    .stall_cnt_o    (stall_cnt_o),
`endif
    .len_o          (len_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int got[$];
  int got_cyc[$];
  int ld[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Behavioural model: table, fill level, and a generator described as
  // "countdown to next sample, next table index, held sample".
  int  m_tab [DEPTH];
  int  m_len = 0, m_wptr = 0, m_idx = 0, m_wait = 0, m_smp = 0, m_stall = 0;
  bit  m_cfg_prev = 0, m_active = 0, m_stalled = 0, m_vld = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_len = 0; m_wptr = 0; m_idx = 0; m_wait = 0; m_smp = 0; m_stall = 0;
      m_cfg_prev = 0; m_active = 0; m_stalled = 0; m_vld = 0;
    end else begin
      bit gen_ok, start, rdy;
      cyc_n++;
      gen_ok = enh_gen_i && !enh_config_i;
      if (clrh_addr_i) m_stall = 0;
      else if (m_vld && !sample_ready_i && m_stall != 16'hFFFF) m_stall++;
      if (clrh_addr_i) begin
        m_idx = 0; m_wait = int'(div_i); m_vld = 0; m_active = 0; m_stalled = 0;
      end else if (!m_active) begin
        if (gen_ok && m_len != 0) begin m_active = 1; m_wait = 0; end
      end else if (m_stalled) begin
        if (sample_ready_i) begin m_vld = 0; m_stalled = 0; end
      end else if (m_vld && !sample_ready_i) begin
        m_stalled = 1;
      end else if (!gen_ok) begin
        m_vld = 0; m_active = 0;
      end else if (m_wait == 0) begin
        m_smp = m_tab[m_idx]; m_vld = 1; m_wait = int'(div_i);
        m_idx = (m_idx + 1) % m_len;
      end else begin
        m_vld = 0; m_wait--;
      end
      start = enh_config_i && !m_cfg_prev;
      rdy   = enh_config_i && !start && (m_len < DEPTH);
      if (start) begin
        m_len = 0; m_wptr = 0;
      end else if (cfg_valid_i && rdy) begin
        m_tab[m_wptr] = int'(cfg_data_i); m_wptr++; m_len++;
      end
      m_cfg_prev = enh_config_i;
    end
  end

  always @(negedge clk) begin
    chk("valid", sample_valid_o, m_vld);
    if (m_vld) chk("sample", sample_o, m_smp);
    chk("len", len_o, m_len);
    chk("cfg_ready", cfg_ready_o, enh_config_i && m_cfg_prev && (m_len < DEPTH));
`ifdef FG_STALL_CNT_EN
    chk("stall_cnt", stall_cnt_o, m_stall);
`endif
    if (sample_valid_o && sample_ready_i) begin
      got.push_back(int'(sample_o));
      got_cyc.push_back(cyc_n);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load();
    enh_gen_i = 0; sample_ready_i = 1; cfg_valid_i = 0;
    repeat (3) cyc();
    enh_config_i = 1; cyc();
    foreach (ld[i]) begin cfg_valid_i = 1; cfg_data_i = DATA_W'(ld[i]); cyc(); end
    cfg_valid_i = 0; enh_config_i = 0; cyc();
  endtask

  task automatic clear_and_go(input int div);
    clrh_addr_i = 1; cyc(); clrh_addr_i = 0;
    div_i = DIV_W'(div); sample_ready_i = 1; enh_gen_i = 1;
    got.delete(); got_cyc.delete();
  endtask

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int e1[6];
    int e2[4];
    int v4[4];
    int exp_held;
    int n;
    e1 = '{4, 7, 9, 2, 4, 7};
    e2 = '{1, 2, 3, 1};
    v4 = '{4, 7, 9, 2};

    repeat (3) cyc();
    @(negedge clk);
    chk("rst_sample", sample_o, 0);
    chk("rst_valid", sample_valid_o, 0);
    chk("rst_len", len_o, 0);
    chk("rst_cfg_ready", cfg_ready_o, 0);
    cyc(); rst = 0; cyc();

    // Load and replay at full rate
    ld.delete(); foreach (v4[i]) ld.push_back(v4[i]);
    load();
    @(negedge clk); chk("load_len", len_o, 4);
    clear_and_go(0);
    repeat (10) cyc();
    chk("s1_count", got.size() >= 6, 1);
    for (int i = 0; i < 6; i++) chk("s1_seq", got[i], e1[i]);
    chk("s1_rate", got_cyc[5] - got_cyc[0], 5);

    // Divider of 4 cycles
    ld.delete(); ld.push_back(1); ld.push_back(2); ld.push_back(3);
    load();
    clear_and_go(3);
    repeat (20) cyc();
    chk("div_count", got.size() >= 4, 1);
    for (int i = 0; i < 4; i++) chk("div_seq", got[i], e2[i]);
    chk("div_period_a", got_cyc[1] - got_cyc[0], 4);
    chk("div_period_b", got_cyc[3] - got_cyc[2], 4);

    // Backpressure for 5 cycles
    clear_and_go(0);
    repeat (4) cyc();
    sample_ready_i = 0;
    exp_held = (got.size() % 3) + 1;
    repeat (5) begin
      cyc(); @(negedge clk);
      chk("bp_valid_held", sample_valid_o, 1);
      chk("bp_sample_held", sample_o, exp_held);
    end
    sample_ready_i = 1;
    repeat (10) cyc();
    chk("bp_count", got.size() >= 8, 1);
    foreach (got[i]) chk("bp_seq", got[i], (i % 3) + 1);

    // Full table: DEPTH+2 writes, the last two ignored
    enh_gen_i = 0; repeat (3) cyc();
    enh_config_i = 1; cyc();
    for (int i = 0; i < DEPTH + 2; i++) begin
      cfg_valid_i = 1; cfg_data_i = DATA_W'(100 + i);
      if (i == DEPTH) begin
        @(negedge clk);
        chk("full_cfg_ready", cfg_ready_o, 0);
        chk("full_len", len_o, DEPTH);
      end
      cyc();
    end
    cfg_valid_i = 0; enh_config_i = 0; cyc();
    clear_and_go(0);
    repeat (22) cyc();
    chk("full_count", got.size() >= DEPTH + 1, 1);
    for (int i = 0; i <= DEPTH; i++) chk("full_seq", got[i], 100 + (i % DEPTH));

    // Clear mid-stream, replay restarts at entry 0
    clrh_addr_i = 1; cyc(); clrh_addr_i = 0;
    @(negedge clk); chk("clr_valid_drop", sample_valid_o, 0);
    got.delete(); got_cyc.delete();
    repeat (4) cyc();
    chk("clr_restart", got[0], 100);
    enh_gen_i = 0; repeat (3) cyc();
    enh_config_i = 1; cyc();
    @(negedge clk); chk("new_session_len", len_o, 0);
    enh_config_i = 0; cyc();

    // Async reset while stalled
    ld.delete(); ld.push_back(5); ld.push_back(6);
    load();
    clear_and_go(0);
    repeat (3) cyc();
    sample_ready_i = 0;
    repeat (3) cyc();
    @(negedge clk); chk("pre_rst_valid", sample_valid_o, 1);
    #2 rst = 1;
    #1;
    chk("arst_valid", sample_valid_o, 0);
    chk("arst_len", len_o, 0);
`ifdef FG_STALL_CNT_EN
    chk("arst_stall_cnt", stall_cnt_o, 0);
`endif
    enh_gen_i = 0; sample_ready_i = 0;
    cyc(); cyc(); rst = 0; cyc();

    // Randomised sessions with random backpressure, clears, divider and gen toggles
    for (int r = 0; r < 25; r++) begin
      enh_gen_i = 0; sample_ready_i = 1; clrh_addr_i = 0;
      repeat (3) cyc();
      n = $urandom_range(1, DEPTH + 2);
      enh_config_i = 1; cyc();
      for (int i = 0; i < n; i++) begin
        cfg_valid_i = ($urandom_range(0, 3) != 0);
        cfg_data_i  = DATA_W'($urandom);
        cyc();
      end
      cfg_valid_i = 0; enh_config_i = 0;
      clrh_addr_i = 1; div_i = DIV_W'($urandom_range(0, 3)); cyc(); clrh_addr_i = 0;
      repeat (60) begin
        sample_ready_i = ($urandom_range(0, 3) != 0);
        clrh_addr_i    = ($urandom_range(0, 29) == 0);
        enh_gen_i      = ($urandom_range(0, 24) != 0);
        if ($urandom_range(0, 19) == 0) div_i = DIV_W'($urandom_range(0, 4));
        cyc();
      end
      clrh_addr_i = 0;
    end
    enh_gen_i = 0; sample_ready_i = 1;
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
